// File: rtl/simple_alu_wb_buffer_pkg.sv
// ---------------------------------------------------------------------------
// simple_alu_wb_buffer_pkg
// Shared writeback types for the execution lanes and FU sizing constants.
//   exeFlgs     - execution status flags carried with every result
//   wbPkt       - result packet presented to the writeback / bypass network
//   wbBufEntry  - one slot of the simple-ALU writeback buffer (packet + toggle)
// ---------------------------------------------------------------------------

`ifndef SIMPLE_WB_BUF_DEPTH
`define SIMPLE_WB_BUF_DEPTH 4
`endif

package simple_alu_wb_buffer_pkg;

    localparam int LOG_REG_W = 5;
    localparam int PHY_REG_W = 6;
    localparam int DATA_W    = 32;
    localparam int AL_ID_W   = 5;

    // Simple-ALU writeback buffer sizing, kept beside the other FU sizing values.
    localparam int SIMPLE_WB_BUF_DEPTH    = `SIMPLE_WB_BUF_DEPTH;
    localparam int SIMPLE_WB_STALL_MARGIN = 1;

    typedef struct packed {
        logic mispredict;
        logic exception;
        logic overflow;
        logic is_branch;
    } exeFlgs;

    typedef struct packed {
        logic                 valid;
        exeFlgs               flags;
        logic [LOG_REG_W-1:0] logDest;
        logic [PHY_REG_W-1:0] phyDest;
        logic [DATA_W-1:0]    destData;
        logic [AL_ID_W-1:0]   alID;
    } wbPkt;

    typedef struct packed {
        wbPkt pkt;
        logic toggle;
    } wbBufEntry;

endpackage

// File: rtl/simple_alu_wb_buffer_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// wb_fifo_ctrl
// Pointer and occupancy bookkeeping for the simple-ALU writeback buffer.
// Qualifies push/pop against flush and full/empty, tracks head/tail/count,
// produces the registered lookahead stall and the sticky overflow flag.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   push_req          incoming packet valid
//   pop_req           writeback grant for the head entry
//   flush             squash everything at the next edge
//   push_en, pop_en   qualified write / read strobes for the storage array
//   head, tail        read / write pointers
//   count             current occupancy
//   empty             count == 0
//   stall             registered, count >= DEPTH-STALL_MARGIN
//   overflow          sticky: push dropped because the buffer was full
// ---------------------------------------------------------------------------

module wb_fifo_ctrl
    import simple_alu_wb_buffer_pkg::*;
#(
    parameter int DEPTH        = SIMPLE_WB_BUF_DEPTH,
    parameter int STALL_MARGIN = SIMPLE_WB_STALL_MARGIN
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_req,
    input  logic                     pop_req,
    input  logic                     flush,
    output logic                     push_en,
    output logic                     pop_en,
    output logic [$clog2(DEPTH)-1:0] head,
    output logic [$clog2(DEPTH)-1:0] tail,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     stall,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - STALL_MARGIN);

    logic             full;
    logic             drop;
    logic [CNT_W-1:0] count_nxt;

    // Occupancy, not pointer compare, decides full/empty so head==tail is unambiguous.
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    assign pop_en  = pop_req && !empty && !flush;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign push_en = push_req && !flush && (!full || pop_en);
    assign drop    = push_req && !flush && full && !pop_en;

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (push_en && !pop_en) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop_en && !push_en) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            stall    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (pop_en) begin
                    head <= head + PTR_W'(1);
                end
                if (push_en) begin
                    tail <= tail + PTR_W'(1);
                end
            end
            count <= count_nxt;
            // Registered from next-cycle occupancy so stall tracks count_o edge for edge.
            stall <= (count_nxt >= STALL_CNT);
            // Flush does not clear this: a drop is a protocol error kept until reset.
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/simple_alu_wb_buffer.sv
// ---------------------------------------------------------------------------
// simple_alu_wb_buffer
// Output buffer between the simple ALU and the shared writeback port. Holds
// results (plus their toggle marker) in FIFO order until the writeback arbiter
// grants the head entry, and raises a lookahead stall toward issue.
// Ports:
//   clk            clock
//   reset_n        synchronous active-low reset
//   wbPacket_i     ALU result, pushed when wbPacket_i.valid
//   toggleFlag_i   toggle marker travelling with wbPacket_i
//   flush_i        recovery flush, empties the buffer at the next edge
//   wbGrant_i      writeback port accepts the head entry this cycle
//   wbPacket_o     head entry, all zero when empty
//   toggleFlag_o   one-cycle pulse the cycle after a toggle entry is granted
//   stall_o        registered lookahead stall toward issue
//   overflow_o     sticky: a push was dropped while full
//   count_o        occupancy
// ---------------------------------------------------------------------------

module simple_alu_wb_buffer
    import simple_alu_wb_buffer_pkg::*;
#(
    parameter int DEPTH        = SIMPLE_WB_BUF_DEPTH,
    parameter int STALL_MARGIN = SIMPLE_WB_STALL_MARGIN
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  wbPkt                   wbPacket_i,
    input  logic                   toggleFlag_i,
    input  logic                   flush_i,
    input  logic                   wbGrant_i,
    output wbPkt                   wbPacket_o,
    output logic                   toggleFlag_o,
    output logic                   stall_o,
    output logic                   overflow_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             push_en;
    logic             pop_en;
    logic             empty;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    wbBufEntry        entries [DEPTH];
    wbBufEntry        push_entry;

    wb_fifo_ctrl #(
        .DEPTH        (DEPTH),
        .STALL_MARGIN (STALL_MARGIN)
    ) u_ctrl (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_req (wbPacket_i.valid),
        .pop_req  (wbGrant_i),
        .flush    (flush_i),
        .push_en  (push_en),
        .pop_en   (pop_en),
        .head     (head),
        .tail     (tail),
        .count    (count_o),
        .empty    (empty),
        .stall    (stall_o),
        .overflow (overflow_o)
    );

    always_comb begin
        push_entry        = '0;
        push_entry.pkt    = wbPacket_i;
        push_entry.toggle = toggleFlag_i;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            toggleFlag_o <= 1'b0;
        end else begin
            if (flush_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    entries[i].pkt.valid <= 1'b0;
                end
            end else if (push_en) begin
                // At full with a same-cycle pop, tail==head: the head is read
                // this cycle before being overwritten at the edge.
                entries[tail] <= push_entry;
            end
            toggleFlag_o <= pop_en && entries[head].toggle;
        end
    end

    // Gate on occupancy so stale slots never leak out when empty.
    always_comb begin
        wbPacket_o = '0;
        if (!empty) begin
            wbPacket_o = entries[head].pkt;
        end
    end

endmodule
